// File: rtl/usart_loopback.sv
// ============================================================================
// Module      : usart_loopback
// Description : UART-framed loopback. A parallel word is serialized (start,
//               8 data LSB-first, parity, stop) onto an internal line and
//               deserialized back into a registered word with parity check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usart_loopback #(
    parameter int CLKS_PER_BIT  = 1,
    parameter int TX_PARITY_ODD = 0,
    parameter int RX_PARITY_ODD = 0
) (
    input  logic CLK,
    input  logic CLR,
    input  logic CLK_rec,
    input  logic I_0,
    input  logic I_1,
    input  logic I_2,
    input  logic I_3,
    input  logic I_4,
    input  logic I_5,
    input  logic I_6,
    input  logic I_7,
    output logic O_0,
    output logic O_1,
    output logic O_2,
    output logic O_3,
    output logic O_4,
    output logic O_5,
    output logic O_6,
    output logic O_7,
    output logic parity_err,
    output logic transfer
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
    localparam logic c_TX_ODD = (TX_PARITY_ODD != 0);
    localparam logic c_RX_ODD = (RX_PARITY_ODD != 0);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_WAIT   = 3'd5;

    // The receiver-clock pin is kept only for board compatibility.
    logic w_unused_clk_rec;
    assign w_unused_clk_rec = CLK_rec;

    logic [7:0] w_tx_word;
    assign w_tx_word = {I_7, I_6, I_5, I_4, I_3, I_2, I_1, I_0};

    // ------------------------------------------------------------------ TX
    logic [2:0]         r_tx_state, w_tx_state_nxt;
    logic [c_CNT_W-1:0] r_tx_cnt,   w_tx_cnt_nxt;
    logic [2:0]         r_tx_idx,   w_tx_idx_nxt;
    logic [7:0]         r_tx_shift, w_tx_shift_nxt;
    logic               r_tx_par,   w_tx_par_nxt;
    logic               r_txd,      w_txd_nxt;
    logic               w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == c_LAST);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_tx_state <= c_ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // txd is loaded with the value of the bit being entered, so it is
    // registered and changes exactly on bit boundaries.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = w_tx_bit_end ? '0 : r_tx_cnt + c_ONE;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_txd_nxt      = r_txd;
        if (w_tx_bit_end) begin
            case (r_tx_state)
                c_ST_IDLE: begin
                    w_tx_shift_nxt = w_tx_word;
                    w_tx_par_nxt   = (^w_tx_word) ^ c_TX_ODD;
                    w_txd_nxt      = 1'b0;
                    w_tx_state_nxt = c_ST_START;
                end
                c_ST_START: begin
                    w_txd_nxt      = r_tx_shift[0];
                    w_tx_idx_nxt   = 3'd0;
                    w_tx_state_nxt = c_ST_DATA;
                end
                c_ST_DATA: begin
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_idx == 3'd7) begin
                        w_txd_nxt      = r_tx_par;
                        w_tx_state_nxt = c_ST_PARITY;
                    end else begin
                        w_txd_nxt    = r_tx_shift[1];
                        w_tx_idx_nxt = r_tx_idx + 3'd1;
                    end
                end
                c_ST_PARITY: begin
                    w_txd_nxt      = 1'b1;
                    w_tx_state_nxt = c_ST_STOP;
                end
                default: begin
                    w_txd_nxt      = 1'b1;
                    w_tx_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------ RX
    logic [2:0]         r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0] r_rx_cnt,   w_rx_cnt_nxt;
    logic [2:0]         r_rx_idx,   w_rx_idx_nxt;
    logic [7:0]         r_rx_shift, w_rx_shift_nxt;
    logic               r_rx_par,   w_rx_par_nxt;
    logic [7:0]         r_out,      w_out_nxt;
    logic               r_perr,     w_perr_nxt;
    logic               r_transfer, w_transfer_nxt;
    logic               w_rx_bit_end;

    assign w_rx_bit_end = (r_rx_cnt == c_LAST);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_rx_state <= c_ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_out      <= '0;
            r_perr     <= 1'b0;
            r_transfer <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_par   <= w_rx_par_nxt;
            r_out      <= w_out_nxt;
            r_perr     <= w_perr_nxt;
            r_transfer <= w_transfer_nxt;
        end
    end

    // The start-detect sample is cycle 0 of the start bit; every later
    // sample lands floor(N/2) cycles into its bit.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_par_nxt   = r_rx_par;
        w_out_nxt      = r_out;
        w_perr_nxt     = r_perr;
        w_transfer_nxt = 1'b0;
        case (r_rx_state)
            c_ST_IDLE: begin
                if (!r_txd) begin
                    w_rx_idx_nxt = 3'd0;
                    if (c_HALF == '0) begin
                        w_rx_cnt_nxt   = '0;
                        w_rx_state_nxt = c_ST_DATA;
                    end else begin
                        w_rx_cnt_nxt   = c_ONE;
                        w_rx_state_nxt = c_ST_START;
                    end
                end
            end
            c_ST_START: begin
                if (r_rx_cnt == c_HALF) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = r_txd ? c_ST_IDLE : c_ST_DATA;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_ONE;
                end
            end
            c_ST_DATA: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_txd, r_rx_shift[7:1]};
                    if (r_rx_idx == 3'd7) begin
                        w_rx_state_nxt = c_ST_PARITY;
                    end else begin
                        w_rx_idx_nxt = r_rx_idx + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_ONE;
                end
            end
            c_ST_PARITY: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_par_nxt   = r_txd;
                    w_rx_state_nxt = c_ST_STOP;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_ONE;
                end
            end
            c_ST_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt = '0;
                    if (r_txd) begin
                        w_out_nxt      = r_rx_shift;
                        w_perr_nxt     = r_rx_par ^ ((^r_rx_shift) ^ c_RX_ODD);
                        w_transfer_nxt = 1'b1;
                        w_rx_state_nxt = c_ST_IDLE;
                    end else begin
                        // Framing error: drop the byte and wait for an idle line.
                        w_rx_state_nxt = c_ST_WAIT;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_ONE;
                end
            end
            c_ST_WAIT: begin
                if (r_txd) begin
                    w_rx_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign {O_7, O_6, O_5, O_4, O_3, O_2, O_1, O_0} = r_out;
    assign parity_err = r_perr;
    assign transfer   = r_transfer;

endmodule

`default_nettype wire

// File: tb/tb_usart_loopback.sv
// ============================================================================
// Module      : tb_usart_loopback
// Description : Directed self-checking bench for usart_loopback with three
//               parameterizations sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usart_loopback;

    logic       CLK;
    logic       CLR;
    logic       CLK_rec;
    logic [7:0] ia, ib, ic;
    logic [7:0] oa, ob, oc;
    logic       perr_a, perr_b, perr_c;
    logic       xfer_a, xfer_b, xfer_c;

    int vectors;
    int miscompares;

    // A: even/even, N=1.  B: even TX / odd RX, N=1.  C: even/even, N=4.
    usart_loopback #(.CLKS_PER_BIT(1), .TX_PARITY_ODD(0), .RX_PARITY_ODD(0)) u_dut_a (
        .CLK(CLK), .CLR(CLR), .CLK_rec(CLK_rec),
        .I_0(ia[0]), .I_1(ia[1]), .I_2(ia[2]), .I_3(ia[3]),
        .I_4(ia[4]), .I_5(ia[5]), .I_6(ia[6]), .I_7(ia[7]),
        .O_0(oa[0]), .O_1(oa[1]), .O_2(oa[2]), .O_3(oa[3]),
        .O_4(oa[4]), .O_5(oa[5]), .O_6(oa[6]), .O_7(oa[7]),
        .parity_err(perr_a), .transfer(xfer_a)
    );

    usart_loopback #(.CLKS_PER_BIT(1), .TX_PARITY_ODD(0), .RX_PARITY_ODD(1)) u_dut_b (
        .CLK(CLK), .CLR(CLR), .CLK_rec(CLK_rec),
        .I_0(ib[0]), .I_1(ib[1]), .I_2(ib[2]), .I_3(ib[3]),
        .I_4(ib[4]), .I_5(ib[5]), .I_6(ib[6]), .I_7(ib[7]),
        .O_0(ob[0]), .O_1(ob[1]), .O_2(ob[2]), .O_3(ob[3]),
        .O_4(ob[4]), .O_5(ob[5]), .O_6(ob[6]), .O_7(ob[7]),
        .parity_err(perr_b), .transfer(xfer_b)
    );

    usart_loopback #(.CLKS_PER_BIT(4), .TX_PARITY_ODD(0), .RX_PARITY_ODD(0)) u_dut_c (
        .CLK(CLK), .CLR(CLR), .CLK_rec(CLK_rec),
        .I_0(ic[0]), .I_1(ic[1]), .I_2(ic[2]), .I_3(ic[3]),
        .I_4(ic[4]), .I_5(ic[5]), .I_6(ic[6]), .I_7(ic[7]),
        .O_0(oc[0]), .O_1(oc[1]), .O_2(oc[2]), .O_3(oc[3]),
        .O_4(oc[4]), .O_5(oc[5]), .O_6(oc[6]), .O_7(oc[7]),
        .parity_err(perr_c), .transfer(xfer_c)
    );

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        ia = 8'h8D; ib = 8'h8D; ic = 8'hA5;
        for (int e = 1; e <= 3; e++) begin
            tick();
            vectors++;
            if (oa !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_o edge %0d: got %h expected 00", e, oa);
            end
            vectors++;
            if (perr_a !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_perr edge %0d: got %b expected 0", e, perr_a);
            end
            vectors++;
            if (xfer_a !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_xfer edge %0d: got %b expected 0", e, xfer_a);
            end
        end
    endtask

    task automatic test_basic();
        ia  = 8'h8D;
        CLR = 1'b0;
        for (int e = 1; e <= 36; e++) begin
            tick();
            vectors++;
            if (xfer_a !== ((e % 12) == 0)) begin
                miscompares++;
                $display("FAIL basic_xfer edge %0d: got %b expected %b", e, xfer_a, (e % 12) == 0);
            end
            if ((e % 12) == 0) begin
                vectors++;
                if (oa !== 8'h8D) begin
                    miscompares++;
                    $display("FAIL basic_o edge %0d: got %h expected 8d", e, oa);
                end
                vectors++;
                if (perr_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_perr edge %0d: got %b expected 0", e, perr_a);
                end
            end
        end
    endtask

    task automatic test_word_change();
        CLR = 1'b1;
        tick(); tick();
        ia  = 8'h8D;
        CLR = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            if (e == 5) ia = 8'h7F;
            vectors++;
            if (xfer_a !== ((e % 12) == 0)) begin
                miscompares++;
                $display("FAIL word_xfer edge %0d: got %b expected %b", e, xfer_a, (e % 12) == 0);
            end
            if (e == 12 || e == 24) begin
                vectors++;
                if (oa !== ((e == 12) ? 8'h8D : 8'h7F)) begin
                    miscompares++;
                    $display("FAIL word_o edge %0d: got %h expected %h", e, oa, (e == 12) ? 8'h8D : 8'h7F);
                end
                vectors++;
                if (perr_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL word_perr edge %0d: got %b expected 0", e, perr_a);
                end
            end
        end
    endtask

    task automatic test_periodic_reset();
        int k;
        logic [7:0] exp_o;
        ia  = 8'h8D;
        CLR = 1'b1;
        tick(); tick();
        // Offset so CLR toggles never coincide with a clock edge or sample point.
        #11;
        k = 0;
        fork
            begin
                repeat (6) begin
                    #605 CLR = ~CLR;
                end
            end
            begin
                repeat (184) begin
                    tick();
                    if (CLR) begin
                        k = 0;
                        vectors++;
                        if (oa !== 8'h00 || xfer_a !== 1'b0) begin
                            miscompares++;
                            $display("FAIL preset_clear t=%0t: got o=%h xfer=%b expected o=00 xfer=0", $time, oa, xfer_a);
                        end
                    end else begin
                        k++;
                        exp_o = (k >= 12) ? 8'h8D : 8'h00;
                        vectors++;
                        if (xfer_a !== ((k % 12) == 0)) begin
                            miscompares++;
                            $display("FAIL preset_xfer k=%0d: got %b expected %b", k, xfer_a, (k % 12) == 0);
                        end
                        vectors++;
                        if (oa !== exp_o) begin
                            miscompares++;
                            $display("FAIL preset_o k=%0d: got %h expected %h", k, oa, exp_o);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_parity_inject();
        CLR = 1'b1;
        tick(); tick();
        ib  = 8'h8D;
        CLR = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            vectors++;
            if (xfer_b !== ((e % 12) == 0)) begin
                miscompares++;
                $display("FAIL pinj_xfer edge %0d: got %b expected %b", e, xfer_b, (e % 12) == 0);
            end
            if (e == 12 || e == 24) begin
                vectors++;
                if (ob !== ((e == 12) ? 8'h8D : 8'h01)) begin
                    miscompares++;
                    $display("FAIL pinj_o edge %0d: got %h expected %h", e, ob, (e == 12) ? 8'h8D : 8'h01);
                end
                vectors++;
                if (perr_b !== 1'b1) begin
                    miscompares++;
                    $display("FAIL pinj_perr edge %0d: got %b expected 1", e, perr_b);
                end
            end
            if (e == 12) ib = 8'h01;
        end
    endtask

    task automatic test_baud_divider();
        int first;
        int second;
        int pulses;
        CLR = 1'b1;
        tick(); tick();
        ic  = 8'hA5;
        CLR = 1'b0;
        first  = 0;
        second = 0;
        pulses = 0;
        for (int e = 1; e <= 120; e++) begin
            tick();
            CLK_rec = 1'($urandom_range(0, 1));
            if (xfer_c === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first = e;
                    vectors++;
                    if (oc !== 8'hA5 || perr_c !== 1'b0) begin
                        miscompares++;
                        $display("FAIL baud_data: got o=%h perr=%b expected o=a5 perr=0", oc, perr_c);
                    end
                end else if (second == 0) begin
                    second = e;
                end
            end
        end
        vectors++;
        if (first < 47 || first > 49) begin
            miscompares++;
            $display("FAIL baud_first: got edge %0d expected 47..49", first);
        end
        vectors++;
        if (second - first != 48) begin
            miscompares++;
            $display("FAIL baud_period: got %0d expected 48", second - first);
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL baud_pulses: got %0d expected 2", pulses);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        CLR         = 1'b1;
        CLK_rec     = 1'b0;
        ia = 8'h8D; ib = 8'h8D; ic = 8'hA5;
        test_reset();
        test_basic();
        test_word_change();
        test_periodic_reset();
        test_parity_inject();
        test_baud_divider();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/usart_loopback.md
Name: usart_loopback

Overview:
- Self-contained USART loopback block for bring-up of the serial link.
- An 8-bit parallel word is serialized into a UART frame (start, 8 data bits LSB-first, parity, stop) on an internal line.
- The frame is deserialized by a receiver on the same line, which presents the word in parallel with a parity check and a completion pulse.
- Sits between the on-board parallel source and the register/monitor logic; the internal serial line is not a port.

Parameters:
- CLKS_PER_BIT, 1, CLK cycles per serial bit (>=1); the receiver samples at cycle floor(CLKS_PER_BIT/2) of each bit.
- TX_PARITY_ODD, 0, 0 = transmitter sends even parity, 1 = odd.
- RX_PARITY_ODD, 0, 0 = receiver checks even parity, 1 = odd. A mismatch against TX_PARITY_ODD is a deliberate error-injection mode.

Ports:
- CLK  in  1  sole clock; all logic on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- CLK_rec  in  1  reserved receiver-clock pin kept for board compatibility; ignored, no logic depends on it.
- I_0..I_7  in  1 each  parallel transmit word, I_0 = LSB.
- O_0..O_7  out  1 each  last received word, O_0 = LSB, registered.
- parity_err  out  1  parity result of the last completed frame, registered.
- transfer  out  1  one-cycle pulse when O_* / parity_err are updated.

Behaviour:
- Reset (CLR=1 at a rising edge):
  - Both FSMs go to IDLE; internal line txd=1; all counters 0.
  - O_*=0, parity_err=0, transfer=0.
  - A frame in flight is aborted with no partial update.
- TX FSM states: IDLE, START, DATA(0..7), PARITY, STOP.
  - IDLE lasts exactly 1 bit time with txd=1. At its end, I_0..I_7 are latched into the shift register and the FSM enters START.
  - Bit values: START txd=0; DATA sends latched bits LSB-first; PARITY sends XOR of the 8 bits, inverted if TX_PARITY_ODD; STOP txd=1; then back to IDLE.
  - Transmission is continuous: 12 bit times per frame.
  - I_* changes mid-frame do not affect the current frame; they are used at the next latch.
  - txd is a registered output of the TX FSM.
- RX FSM states: IDLE, START, DATA(0..7), PARITY, STOP; samples txd in the CLK domain.
  - IDLE: a sample of 0 starts a frame. For CLKS_PER_BIT>1, the start bit is re-checked at mid-bit and a 1 there returns the FSM to IDLE.
  - Data bits are shifted in LSB-first at each mid-bit sample; then the parity bit is sampled.
  - STOP sample = 1: O_* <= received byte; parity_err <= 1 if the received parity differs from the parity computed per RX_PARITY_ODD, else 0; transfer=1 for exactly one cycle.
  - STOP sample = 0 (framing error): byte discarded, no transfer, O_* and parity_err unchanged. RX waits for txd=1 before re-arming IDLE.
  - parity_err holds its value between frames; each completed frame overwrites it.
- Latency (CLKS_PER_BIT=1), edge 1 = first rising edge with CLR=0:
  - Edge 1: TX latches I and drives the start bit.
  - Edge 2: RX detects start.
  - Edges 3-10: data bits sampled.
  - Edge 11: parity sampled.
  - Edge 12: stop sampled; O_*/parity_err/transfer registered.
  - transfer is high between edges 12 and 13; subsequent pulses every 12 cycles (edges 24, 36, ...).
  - For general N = CLKS_PER_BIT: first pulse exactly 12*N cycles after reset release (±1 cycle allowed only for N>1), period 12*N.
- Reset asserted mid-operation overrides everything on that edge. On release, both FSMs restart from IDLE aligned as above.

Test Plan:
- Reset: CLR=1 for 3 edges with I=0x8D -> O=0x00, parity_err=0, transfer=0 throughout.
- Basic loopback: I=0x8D (I_0=1,I_1=0,I_2=1,I_3=1,I_4..I_6=0,I_7=1), release CLR -> transfer high only after edge 12; O=0x8D; parity_err=0; next pulses at edges 24, 36.
- Word change: I=0x8D, switch to 0x7F at edge 5 -> first frame O=0x8D, second frame O=0x7F, parity_err=0 on both.
- Periodic reset: CLR toggled every 605 ns with a 20 ns CLK period -> during each low window, pulses at edges 12 and 24 with O=0x8D. Each CLR high clears O to 0x00 and aborts the partial frame with no spurious transfer.
- Parity injection: RX_PARITY_ODD=1, TX_PARITY_ODD=0, I=0x8D -> every frame O=0x8D, parity_err=1. Then I=0x01 -> parity_err=1 still (mismatch independent of data).
- Baud divider: CLKS_PER_BIT=4, I=0xA5 -> first transfer 48±1 cycles after reset release, period 48 cycles, O=0xA5. CLK_rec toggled arbitrarily has no effect.
